// File: rtl/risc15_pkg.sv
// Shared RISC15 constants and the LM/SM sequencer state encoding.
package risc15_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/lmsm_sequencer_pri_enc.sv
// Lowest-set-bit encoder, purely combinational; also used by the hazard unit.
// vld_o is low and idx_o is 0 when no bit is set.
module pri_enc_8_3
  import risc15_pkg::*;
(
  input  logic [NREG-1:0]  req_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = SEL_W'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: one register transfer per cycle from the lowest mask bit up, then a done pulse.
// First transfer one cycle after start; hold freezes the walk, stall_req freezes the pipeline meanwhile.
module lmsm_sequencer
  import risc15_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_mask,
  input  logic              hold,
  output logic              busy,
  output logic              stall_req,
  output logic [SEL_W-1:0]  reg_sel,
  output logic [DATA_W-1:0] mem_addr,
  output logic              xfer_valid,
  output logic              mem_we,
  output logic              rf_we,
  output logic              done
);

  state_e            state_q;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              is_load_q;
  logic [SEL_W-1:0]  enc_idx;
  logic              enc_vld;
  logic              in_xfer, in_idle;

  pri_enc_8_3 u_pri_enc (
    .req_i (mask_q),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  assign mask_d = mask_q & (mask_q - 1'b1);
  assign addr_d = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      addr_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            addr_q    <= base_addr;
            mask_q    <= reg_mask;
            state_q   <= (|reg_mask) ? XFER : DONE;
          end
        end
        XFER: begin
          if (!hold) begin
            mask_q <= mask_d;
            addr_q <= addr_d;
            if (mask_d == '0) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_idle    = (state_q == IDLE);
  assign in_xfer    = (state_q == XFER);
  assign busy       = ~in_idle;
  assign stall_req  = (start & in_idle) | busy;
  assign xfer_valid = in_xfer & enc_vld;
  assign reg_sel    = in_xfer ? enc_idx : '0;
  assign mem_addr   = in_xfer ? addr_q : '0;
  assign mem_we     = xfer_valid & ~is_load_q;
  assign rf_we      = xfer_valid & is_load_q & ~hold;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: transfer-list model checked every cycle plus literal spot checks.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, is_load, hold;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        busy, stall_req, xfer_valid, mem_we, rf_we, done;
  logic [2:0]  reg_sel;
  logic [15:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  lmsm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .base_addr  (base_addr),
    .reg_mask   (reg_mask),
    .hold       (hold),
    .busy       (busy),
    .stall_req  (stall_req),
    .reg_sel    (reg_sel),
    .mem_addr   (mem_addr),
    .xfer_valid (xfer_valid),
    .mem_we     (mem_we),
    .rf_we      (rf_we),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = transferring (pending list non-empty), 2 = done cycle.
  int          ph = 0;
  bit          model_ok = 1'b0;
  bit          m_ld = 1'b0;
  int          q_sel[$];
  logic [15:0] q_addr[$];

  always @(posedge clk) begin
    logic [15:0] a;
    if (reset) begin
      ph = 0;
      q_sel.delete();
      q_addr.delete();
      model_ok = 1'b1;
    end else if (ph == 0) begin
      if (start) begin
        m_ld = is_load;
        a = base_addr;
        for (int b = 0; b < 8; b++) begin
          if (reg_mask[b]) begin
            q_sel.push_back(b);
            q_addr.push_back(a);
            a = a + 16'd1;
          end
        end
        ph = (q_sel.size() != 0) ? 1 : 2;
      end
    end else if (ph == 1) begin
      if (!hold) begin
        void'(q_sel.pop_front());
        void'(q_addr.pop_front());
        if (q_sel.size() == 0) ph = 2;
      end
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    bit x;
    if (model_ok) begin
      x = (ph == 1);
      chk("m_xfer_valid", 32'(xfer_valid), 32'(x));
      chk("m_reg_sel",    32'(reg_sel),    x ? 32'(q_sel[0]) : 32'd0);
      chk("m_mem_addr",   32'(mem_addr),   x ? 32'(q_addr[0]) : 32'd0);
      chk("m_mem_we",     32'(mem_we),     32'(x & !m_ld));
      chk("m_rf_we",      32'(rf_we),      32'(x & m_ld & !hold));
      chk("m_busy",       32'(busy),       32'(ph != 0));
      chk("m_stall_req",  32'(stall_req),  32'((ph != 0) || start));
      chk("m_done",       32'(done),       32'(ph == 2));
    end
  end

  // Called just after a rising edge; returns just after the edge that begins cycle N+1.
  task automatic go(input logic ld, input logic [15:0] base, input logic [7:0] mask);
    start = 1'b1; is_load = ld; base_addr = base; reg_mask = mask;
    @(negedge clk);
    chk("stall_at_start", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; hold = 1'b0;
    base_addr = '0; reg_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // LM 1010_0101 from 0x0040
    go(1'b1, 16'h0040, 8'b1010_0101);
    for (int k = 0; k < 4; k++) begin
      int sels[4] = '{0, 2, 5, 7};
      @(negedge clk);
      chk("t1_sel",   32'(reg_sel), 32'(sels[k]));
      chk("t1_addr",  32'(mem_addr), 32'h40 + 32'(k));
      chk("t1_rf_we", 32'(rf_we), 32'd1);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
    end
    @(negedge clk); chk("t1_done", 32'(done), 32'd1);
    @(negedge clk); chk("t1_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // SM, empty mask
    go(1'b0, 16'h1234, 8'h00);
    @(negedge clk);
    chk("t2_done",  32'(done), 32'd1);
    chk("t2_xv",    32'(xfer_valid), 32'd0);
    chk("t2_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    chk("t2_done_gone", 32'(done), 32'd0);
    chk("t2_stall_gone", 32'(stall_req), 32'd0);
    @(posedge clk); #1;

    // SM, full mask wrapping past 0xFFFF
    go(1'b0, 16'hFFFE, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ea;
      ea = 16'hFFFE + 16'(k);
      @(negedge clk);
      chk("t3_sel",    32'(reg_sel), 32'(k));
      chk("t3_addr",   32'(mem_addr), 32'(ea));
      chk("t3_mem_we", 32'(mem_we), 32'd1);
    end
    @(negedge clk); chk("t3_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // LM 0001_0010 with a two-cycle hold on the first transfer
    go(1'b1, 16'h0100, 8'b0001_0010);
    hold = 1'b1;
    @(negedge clk); chk("t4_sel_h0", 32'(reg_sel), 32'd1); chk("t4_rfwe_h0", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("t4_sel_h1", 32'(reg_sel), 32'd1); chk("t4_rfwe_h1", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    chk("t4_sel_rel", 32'(reg_sel), 32'd1);
    chk("t4_addr_rel", 32'(mem_addr), 32'h100);
    chk("t4_rfwe_rel", 32'(rf_we), 32'd1);
    @(negedge clk); chk("t4_sel2", 32'(reg_sel), 32'd4); chk("t4_addr2", 32'(mem_addr), 32'h101);
    @(negedge clk); chk("t4_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // SM full mask, second start during XFER must be ignored
    go(1'b0, 16'h0010, 8'hFF);
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; base_addr = 16'h0900; reg_mask = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_sel", 32'(reg_sel), 32'd2);
    chk("t5_addr", 32'(mem_addr), 32'h12);
    chk("t5_mem_we", 32'(mem_we), 32'd1);
    repeat (5) @(negedge clk);
    chk("t5_last_addr", 32'(mem_addr), 32'h17);
    @(negedge clk); chk("t5_done", 32'(done), 32'd1);
    @(negedge clk); chk("t5_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // LM full mask, reset during the third transfer
    go(1'b1, 16'h0020, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_sel3", 32'(reg_sel), 32'd2);
    chk("t6_rfwe3", 32'(rf_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_xv", 32'(xfer_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Fresh start after the abort
    go(1'b1, 16'h0007, 8'h81);
    @(negedge clk); chk("t7_sel0", 32'(reg_sel), 32'd0); chk("t7_addr0", 32'(mem_addr), 32'h7);
    @(negedge clk); chk("t7_sel1", 32'(reg_sel), 32'd7); chk("t7_addr1", 32'(mem_addr), 32'h8);
    @(negedge clk); chk("t7_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
